idct4x4: RTL



---
 rtl/dct_pkg.sv | 26 ++
 rtl/idct_mac4.sv | 26 ++
 rtl/idct4x4.sv | 123 ++++++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// Shared definitions for the 4x4 forward/inverse DCT blocks: 128-scaled basis
// matrix, sequencing states and datapath widths.
package dct_pkg;

    localparam int COEF_W = 10;
    localparam int MID_W  = 11;
    localparam int PIX_W  = 8;
    // Dot-product accumulator: 11x11 products summed four times fit in 24 bits.
    localparam int ACC_W  = 24;

    // DCT_C[k][n]: basis row k, sample n, scaled by 128.
    localparam logic signed [7:0] DCT_C [4][4] = '{
        '{ 8'sd64,  8'sd64,  8'sd64,  8'sd64},
        '{ 8'sd83,  8'sd34, -8'sd34, -8'sd83},
        '{ 8'sd64, -8'sd64, -8'sd64,  8'sd64},
        '{ 8'sd34, -8'sd83,  8'sd83, -8'sd34}
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS1,
        ST_PASS2,
        ST_OUTPUT
    } dct_state_t;

endpackage

// File: rtl/idct_mac4.sv
// Combinational 4-term signed dot product, divided by 128 with truncation
// toward zero.
module idct_mac4
    import dct_pkg::*;
(
    input  logic signed [MID_W-1:0] a [4],
    input  logic signed [MID_W-1:0] b [4],
    output logic signed [ACC_W-1:0] q
);

    logic signed [ACC_W-1:0] prod [4];
    logic signed [ACC_W-1:0] sum;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_prod
            assign prod[gi] = ACC_W'(a[gi]) * ACC_W'(b[gi]);
        end
    endgenerate

    always_comb begin
        sum = prod[0] + prod[1] + prod[2] + prod[3];
        // Signed '/' rounds toward zero, matching the forward transform.
        q   = sum / 24'sd128;
    end

endmodule

// File: rtl/idct4x4.sv
// Inverse 4x4 integer DCT: serial coefficient load, two one-element-per-cycle
// matrix passes through a shared MAC, then a 16-sample registered output burst.
module idct4x4
    import dct_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [COEF_W-1:0] in_data,
    output logic                     out_valid,
    output logic signed [PIX_W-1:0]  out_data
);

    dct_state_t state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       out_valid_reg, out_valid_next;
    logic signed [PIX_W-1:0] out_data_reg, out_data_next;

    logic signed [COEF_W-1:0] y_mem [16];
    logic signed [MID_W-1:0]  t_mem [16];
    logic signed [PIX_W-1:0]  x_mem [16];

    logic y_we, t_we, x_we;
    logic [1:0] row_idx, col_idx;

    logic signed [MID_W-1:0] mac_a [4];
    logic signed [MID_W-1:0] mac_b [4];
    logic signed [ACC_W-1:0] mac_q;
    logic signed [PIX_W-1:0] x_sat;

    assign row_idx = cnt_reg[3:2];
    assign col_idx = cnt_reg[1:0];

    // PASS1 forms T = C^T * Y (C transposed), PASS2 forms X = T * C.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_operand
            assign mac_a[gi] = (state_reg == ST_PASS1) ? MID_W'(DCT_C[gi][row_idx])
                                                       : t_mem[{row_idx, 2'(gi)}];
            assign mac_b[gi] = (state_reg == ST_PASS1) ? MID_W'(y_mem[{2'(gi), col_idx}])
                                                       : MID_W'(DCT_C[gi][col_idx]);
        end
    endgenerate

    idct_mac4 u_mac (
        .a (mac_a),
        .b (mac_b),
        .q (mac_q)
    );

    always_comb begin
        if (mac_q > 24'sd127) begin
            x_sat = 8'sd127;
        end else if (mac_q < -24'sd128) begin
            x_sat = -8'sd128;
        end else begin
            x_sat = mac_q[PIX_W-1:0];
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        y_we           = 1'b0;
        t_we           = 1'b0;
        x_we           = 1'b0;
        out_valid_next = 1'b0;
        out_data_next  = '0;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    y_we     = 1'b1;
                    cnt_next = cnt_reg + 4'd1;
                    if (cnt_reg == 4'd15) state_next = ST_PASS1;
                end
            end
            ST_PASS1: begin
                t_we     = 1'b1;
                cnt_next = cnt_reg + 4'd1;
                if (cnt_reg == 4'd15) state_next = ST_PASS2;
            end
            ST_PASS2: begin
                x_we     = 1'b1;
                cnt_next = cnt_reg + 4'd1;
                if (cnt_reg == 4'd15) state_next = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                // cnt wraps to 0 after the 16th sample; that cycle drops out_valid.
                if (out_valid_reg && cnt_reg == 4'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    out_valid_next = 1'b1;
                    out_data_next  = x_mem[cnt_reg];
                    cnt_next       = cnt_reg + 4'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
        end
    end

    always_ff @(posedge clk) begin
        if (y_we) y_mem[cnt_reg] <= in_data;
        if (t_we) t_mem[cnt_reg] <= mac_q[MID_W-1:0];
        if (x_we) x_mem[cnt_reg] <= x_sat;
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

endmodule
